// File: rtl/multiexp_result_tx.sv
// ---------------------------------------------------------------------------
// multiexp_result_tx
//
// Host-bound writer of the multiexp command link. It takes decoded commands
// from the command decoder, fetches wide results from the result store, and
// writes framed 32-bit packets into the output FIFO that PCIe drains.
//
// Packet formats written to the FIFO:
//   result packet : header {op, idx, 16'(res_words)} followed by res_words
//                   data words, least-significant word first, in
//                   consecutive cycles
//   NAK           : single word {8'hEE, op, 16'h0000}
//
// Commands:
//   0x20 READ_RESULT   : one result packet for slot cmd_addr (NAK if out of range)
//   0x40 FLUSH_RESULTS : one result packet per slot, slot 0 .. n_res-1
//   other              : NAK
//
// Ports:
//   clk, resetn        clock; synchronous active-low reset
//   cmd_valid/ready    command handshake. cmd_valid may change freely; a
//                      command (cmd_op, cmd_addr) is consumed on a rising
//                      edge where cmd_valid & cmd_ready. cmd_ready is high
//                      only while the block is idle, so commands offered
//                      while busy stay pending and are not consumed.
//   cmd_op, cmd_addr   opcode byte and result index
//   res_req/res_addr   result fetch request, held until res_ack
//   res_ack/res_data   result store answer; res_data sampled with res_ack
//   fifo_datao         word to the output FIFO (holds when not writing)
//   fifo_wren          one word written per asserted cycle
//   fifo_usedw_out     output FIFO fill level, MSB = full
//   busy               ~cmd_ready
// ---------------------------------------------------------------------------
module multiexp_result_tx #(
    parameter int fifo_widthu  = 13,
    parameter int res_words    = 32,
    parameter int n_res        = 2,
    parameter int space_margin = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [7:0]                 cmd_op,
    input  logic [7:0]                 cmd_addr,
    output logic                       res_req,
    output logic [7:0]                 res_addr,
    input  logic                       res_ack,
    input  logic [32*res_words-1:0]    res_data,
    output logic [31:0]                fifo_datao,
    output logic                       fifo_wren,
    input  logic [fifo_widthu:0]       fifo_usedw_out,
    output logic                       busy
);

    localparam int CW = (res_words > 1) ? $clog2(res_words) : 1;
    localparam int UW = fifo_widthu + 1;

    // Highest fill level at which a whole packet (plus margin for the
    // FIFO's usedw latency) is guaranteed to fit. The full flag (MSB) makes
    // usedw exceed both limits, so a full FIFO always stalls.
    localparam logic [UW-1:0] PKT_LIMIT = UW'((2 ** fifo_widthu) - (res_words + 1 + space_margin));
    localparam logic [UW-1:0] NAK_LIMIT = UW'((2 ** fifo_widthu) - (1 + space_margin));

    localparam logic [7:0]    OP_READ   = 8'h20;
    localparam logic [7:0]    OP_FLUSH  = 8'h40;
    localparam logic [7:0]    LAST_IDX  = 8'(n_res - 1);
    localparam logic [8:0]    NUM_RES   = 9'(n_res);
    localparam logic [CW-1:0] LAST_WORD = CW'(res_words - 1);
    localparam logic [15:0]   HDR_LEN   = 16'(res_words);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_FETCH      = 3'd1,
        S_WAIT_SPACE = 3'd2,
        S_HDR        = 3'd3,
        S_DATA       = 3'd4,
        S_NAK        = 3'd5
    } state_t;

    state_t                   state, state_nxt;
    logic [7:0]               op_q, op_nxt;
    logic [7:0]               idx_q, idx_nxt;
    logic [CW-1:0]            cnt_q, cnt_nxt;
    logic [32*res_words-1:0]  shreg_q, shreg_nxt;
    logic [31:0]              datao_q, datao_nxt;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= S_IDLE;
            op_q    <= 8'h00;
            idx_q   <= 8'h00;
            cnt_q   <= '0;
            shreg_q <= '0;
            datao_q <= 32'h0000_0000;
        end else begin
            state   <= state_nxt;
            op_q    <= op_nxt;
            idx_q   <= idx_nxt;
            cnt_q   <= cnt_nxt;
            shreg_q <= shreg_nxt;
            datao_q <= datao_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        op_nxt     = op_q;
        idx_nxt    = idx_q;
        cnt_nxt    = cnt_q;
        shreg_nxt  = shreg_q;
        datao_nxt  = datao_q;
        cmd_ready  = 1'b0;
        res_req    = 1'b0;
        fifo_wren  = 1'b0;
        fifo_datao = datao_q;

        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_nxt = cmd_op;
                    if ((cmd_op == OP_READ) && ({1'b0, cmd_addr} < NUM_RES)) begin
                        idx_nxt   = cmd_addr;
                        state_nxt = S_FETCH;
                    end else if (cmd_op == OP_FLUSH) begin
                        idx_nxt   = 8'h00;
                        state_nxt = S_FETCH;
                    end else begin
                        state_nxt = S_NAK;
                    end
                end
            end

            S_FETCH: begin
                res_req = 1'b1;
                if (res_ack) begin
                    shreg_nxt = res_data;
                    state_nxt = S_WAIT_SPACE;
                end
            end

            // Space is checked once; from here on the packet streams
            // without looking at usedw again.
            S_WAIT_SPACE: begin
                if (fifo_usedw_out <= PKT_LIMIT) begin
                    state_nxt = S_HDR;
                end
            end

            S_HDR: begin
                fifo_wren  = 1'b1;
                fifo_datao = {op_q, idx_q, HDR_LEN};
                datao_nxt  = {op_q, idx_q, HDR_LEN};
                cnt_nxt    = '0;
                state_nxt  = S_DATA;
            end

            // The shift register presents the next word in its low 32 bits,
            // giving least-significant-word-first order.
            S_DATA: begin
                fifo_wren  = 1'b1;
                fifo_datao = shreg_q[31:0];
                datao_nxt  = shreg_q[31:0];
                shreg_nxt  = shreg_q >> 32;
                cnt_nxt    = cnt_q + 1'b1;
                if (cnt_q == LAST_WORD) begin
                    if ((op_q == OP_FLUSH) && (idx_q < LAST_IDX)) begin
                        idx_nxt   = idx_q + 8'h01;
                        state_nxt = S_FETCH;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end

            // The NAK word is written in the first cycle with enough room.
            S_NAK: begin
                if (fifo_usedw_out <= NAK_LIMIT) begin
                    fifo_wren  = 1'b1;
                    fifo_datao = {8'hEE, op_q, 16'h0000};
                    datao_nxt  = {8'hEE, op_q, 16'h0000};
                    state_nxt  = S_IDLE;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign res_addr = idx_q;
    assign busy     = ~cmd_ready;

endmodule

// File: tb/tb_multiexp_result_tx.sv
// ---------------------------------------------------------------------------
// tb_multiexp_result_tx
//
// Self-checking bench for multiexp_result_tx. A packet-level model turns
// each accepted command into the list of FIFO words it must produce
// (header, result words, or a NAK word) and the list of result slots that
// must be fetched. A monitor compares every FIFO write in order against
// that list and checks that packets are written in consecutive cycles.
// A result-store responder answers fetches with random latency and checks
// the requested slot.
// ---------------------------------------------------------------------------
module tb_multiexp_result_tx;

    localparam int FW = 13;
    localparam int RW = 32;
    localparam int NR = 2;
    localparam int SM = 4;
    localparam int PKT_OK = (2 ** FW) - (RW + 1 + SM);   // 8155

    logic               clk;
    logic               resetn;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [7:0]         cmd_op;
    logic [7:0]         cmd_addr;
    logic               res_req;
    logic [7:0]         res_addr;
    logic               res_ack;
    logic [32*RW-1:0]   res_data;
    logic [31:0]        fifo_datao;
    logic               fifo_wren;
    logic [FW:0]        fifo_usedw_out;
    logic               busy;

    multiexp_result_tx #(
        .fifo_widthu (FW),
        .res_words   (RW),
        .n_res       (NR),
        .space_margin(SM)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_addr      (cmd_addr),
        .res_req       (res_req),
        .res_addr      (res_addr),
        .res_ack       (res_ack),
        .res_data      (res_data),
        .fifo_datao    (fifo_datao),
        .fifo_wren     (fifo_wren),
        .fifo_usedw_out(fifo_usedw_out),
        .busy          (busy)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard state ----------------
    logic [31:0] results [NR][RW];
    logic [31:0] exp_q[$];
    bit          cont_q[$];          // 1: the next word must follow in the next cycle
    int          exp_fetch_q[$];
    int          checks    = 0;
    int          failures  = 0;
    int          words_seen = 0;
    bit          pend_cont = 1'b0;
    bit          usedw_rand = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void push_pkt(input logic [7:0] op, input int slot);
        exp_q.push_back({op, 8'(slot), 16'(RW)});
        cont_q.push_back(1'b1);
        for (int k = 0; k < RW; k++) begin
            exp_q.push_back(results[slot][k]);
            cont_q.push_back(k != RW - 1);
        end
        exp_fetch_q.push_back(slot);
    endfunction

    function automatic void model_cmd(input logic [7:0] op, input logic [7:0] addr);
        if (op == 8'h20 && int'(addr) < NR) begin
            push_pkt(op, int'(addr));
        end else if (op == 8'h40) begin
            for (int i = 0; i < NR; i++) push_pkt(op, i);
        end else begin
            exp_q.push_back({8'hEE, op, 16'h0000});
            cont_q.push_back(1'b0);
        end
    endfunction

    // ---------------- FIFO-side monitor ----------------
    always @(negedge clk) begin
        if (pend_cont) check_val("contig", fifo_wren, 1'b1);
        pend_cont = 1'b0;
        if (fifo_wren) begin
            if (exp_q.size() == 0) begin
                check_val("spurious_wren", fifo_wren, 1'b0);
            end else begin
                check_val("fifo_word", fifo_datao, exp_q.pop_front());
                pend_cont = cont_q.pop_front();
                words_seen++;
            end
        end
    end

    // ---------------- result store responder ----------------
    initial begin : responder
        bit in_req;
        int dly;
        int a;
        in_req   = 1'b0;
        dly      = 0;
        res_ack  = 1'b0;
        res_data = '0;
        forever begin
            @(negedge clk);
            #1;
            if (res_ack) begin
                res_ack = 1'b0;
                in_req  = 1'b0;
            end else if (in_req) begin
                if (dly == 0) begin
                    a = int'(res_addr);
                    for (int k = 0; k < RW; k++)
                        res_data[32*k +: 32] = (a < NR) ? results[a][k] : 32'hDEAD_BEEF;
                    res_ack = 1'b1;
                end else begin
                    dly--;
                end
            end else if (res_req) begin
                in_req = 1'b1;
                dly    = $urandom_range(0, 3);
                if (exp_fetch_q.size() == 0) check_val("fetch_unexp", res_req, 1'b0);
                else check_val("res_addr", res_addr, exp_fetch_q.pop_front());
            end else if ($urandom_range(0, 7) == 0) begin
                // stray acknowledge outside a fetch carrying junk
                for (int k = 0; k < RW; k++) res_data[32*k +: 32] = $urandom;
                res_ack = 1'b1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
        #1;
        if (usedw_rand) begin
            if ($urandom_range(0, 9) < 7) fifo_usedw_out = (FW+1)'($urandom_range(0, PKT_OK));
            else fifo_usedw_out = (FW+1)'($urandom_range(PKT_OK + 1, 2 ** FW));
        end
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [7:0] addr);
        int n;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        n = 0;
        while (!cmd_ready && n < 5000) begin
            step();
            n++;
        end
        if (n >= 5000) check_val("accept_timeout", cmd_ready, 1'b1);
        model_cmd(op, addr);
        step();
        cmd_valid = 1'b0;
        cmd_op    = $urandom;
        cmd_addr  = $urandom;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_fetch_q.size() != 0 || !cmd_ready) && n < 5000) begin
            step();
            n++;
        end
        if (n >= 5000) check_val("idle_timeout", exp_q.size(), 0);
    endtask

    task automatic fill_results(input bit pattern);
        for (int s = 0; s < NR; s++)
            for (int k = 0; k < RW; k++)
                results[s][k] = pattern ? (32'hA500_0000 + 32'(k) + 32'(s << 16)) : $urandom;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int base;
        int n;
        logic [13:0] stall_lvls [2];
        logic [7:0]  op;
        stall_lvls[0] = 14'd8156;
        stall_lvls[1] = 14'd8192;

        resetn         = 1'b0;
        cmd_valid      = 1'b0;
        cmd_op         = 8'h00;
        cmd_addr       = 8'h00;
        fifo_usedw_out = '0;
        fill_results(1'b1);

        repeat (3) step();
        check_val("rst_cmd_ready", cmd_ready, 1'b1);
        check_val("rst_res_req", res_req, 1'b0);
        check_val("rst_res_addr", res_addr, 8'h00);
        check_val("rst_wren", fifo_wren, 1'b0);
        check_val("rst_datao", fifo_datao, 32'h0);
        check_val("rst_busy", busy, 1'b0);
        resetn = 1'b1;
        step();

        // READ slot 1 at exactly the space threshold: streams.
        fifo_usedw_out = 14'(PKT_OK);
        send_cmd(8'h20, 8'h01);
        check_val("busy_after_accept", busy, 1'b1);
        wait_idle();

        // One above threshold and FIFO full: no write until space appears.
        foreach (stall_lvls[i]) begin
            fifo_usedw_out = stall_lvls[i];
            send_cmd(8'h20, 8'h00);
            repeat (40) begin
                check_val("stall_wren", fifo_wren, 1'b0);
                step();
            end
            fifo_usedw_out = 14'(PKT_OK);
            wait_idle();
        end
        fifo_usedw_out = '0;

        // FLUSH: both slots in order.
        send_cmd(8'h40, 8'h00);
        wait_idle();

        // Unsupported op and out-of-range read produce a NAK only.
        send_cmd(8'h08, 8'h00);
        wait_idle();
        send_cmd(8'h20, 8'h05);
        wait_idle();

        // Back-to-back READs with cmd_valid held throughout.
        base = words_seen;
        cmd_valid = 1'b1;
        cmd_op    = 8'h20;
        cmd_addr  = 8'h00;
        model_cmd(8'h20, 8'h00);
        step();
        cmd_addr = 8'h01;
        n = 0;
        while (!cmd_ready && n < 2000) begin
            step();
            n++;
        end
        check_val("b2b_first_done", words_seen - base, RW + 1);
        model_cmd(8'h20, 8'h01);
        step();
        cmd_valid = 1'b0;
        wait_idle();

        // Reset after the 10th data word of a READ.
        base = words_seen;
        send_cmd(8'h20, 8'h00);
        n = 0;
        while (words_seen < base + 11 && n < 2000) begin
            step();
            n++;
        end
        check_val("rst_mid_reached", words_seen - base, 11);
        resetn = 1'b0;
        exp_q.delete();
        cont_q.delete();
        exp_fetch_q.delete();
        pend_cont = 1'b0;
        step();
        check_val("midrst_wren", fifo_wren, 1'b0);
        check_val("midrst_res_req", res_req, 1'b0);
        check_val("midrst_datao", fifo_datao, 32'h0);
        resetn = 1'b1;
        repeat (40) step();
        check_val("midrst_cmd_ready", cmd_ready, 1'b1);

        // Randomized commands, random fill level, pipelined submission.
        fill_results(1'b0);
        usedw_rand = 1'b1;
        for (int i = 0; i < 25; i++) begin
            case ($urandom_range(0, 5))
                0, 1, 2: send_cmd(8'h20, 8'($urandom_range(0, NR - 1)));
                3:       send_cmd(8'h40, 8'($urandom));
                4:       send_cmd(8'h20, 8'($urandom_range(NR, 255)));
                default: begin
                    op = 8'($urandom);
                    if (op == 8'h20 || op == 8'h40) op = op ^ 8'h01;
                    send_cmd(op, 8'($urandom));
                end
            endcase
            repeat ($urandom_range(0, 3)) step();
        end
        wait_idle();
        usedw_rand = 1'b0;
        fifo_usedw_out = '0;
        repeat (10) step();

        check_val("exp_left", exp_q.size(), 0);
        check_val("fetch_left", exp_fetch_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
